muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle controller for the RV32M multiply/divide path in the EX stage. It accepts an M-extension operation from the ID/EX register and sequences a registered multiply or a 32-iteration restoring divide. While an operation is in flight it drives a stall that freezes PC, IF/ID and ID/EX. It presents the 32-bit result for capture into EX/MEM on the single cycle the stall drops.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  EX holds a valid M-extension instruction (funct7 = 0000001, R-type)
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_a  in  XLEN  rs1 value (post-forwarding)
- operand_b  in  XLEN  rs2 value (post-forwarding)
- flush  in  1  abort the current operation (branch/exception flush of EX)
- stall  out  1  hold PC, IF/ID, ID/EX; combinational
- busy  out  1  state not IDLE; registered
- done  out  1  result valid this cycle; registered
- result  out  XLEN  operation result; held until the next done

## Operation
- States:
  - IDLE: accepts start.
  - MUL: one cycle; the 64-bit product is registered.
  - DIV_RUN: 32 iterations on |a|, |b| magnitudes.
  - DIV_FIX: sign correction of quotient/remainder.
  - DONE: one cycle; done=1.
- Transitions:
  - IDLE + start:
    - op[2]=0 → MUL.
    - op[2]=1 and special case → DONE.
    - otherwise → DIV_RUN.
  - MUL → DONE.
  - DIV_RUN → DIV_FIX after iteration counter reaches 31.
  - DIV_FIX → DONE.
  - DONE → IDLE unconditionally.
- start is sampled only in IDLE. It is ignored in DONE: the EX instruction still holds start during its own DONE cycle and must not restart.
- Operands and op are latched on acceptance. Later input changes are ignored.
- Multiply result select from the 64-bit product:
  - MUL: low 32 bits.
  - MULH: high 32 bits, signed×signed.
  - MULHSU: high 32 bits, signed×unsigned.
  - MULHU: high 32 bits, unsigned×unsigned.
- Signed divide: dividend and divisor are negated to magnitudes. Quotient is negated iff the operand signs differ. Remainder takes the dividend's sign.
- Special cases (fast path, no iterations):
  - Divide by zero: quotient = 0xFFFFFFFF; remainder = operand_a.
  - Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM only): quotient = 0x80000000; remainder = 0.
- stall = (state==IDLE & start & !flush) | (state ∉ {IDLE, DONE}).
- flush in any state except DONE → IDLE at the next edge. No done, result unchanged.
- flush in DONE is a don't-care: the state goes to IDLE regardless.
- Simultaneous start and flush in IDLE: the operation is not accepted and stall=0.
- Reset (asynchronous, any time including mid-divide): state=IDLE, busy=0, done=0, result=0, counter=0. stall=0 whenever reset is high.

## Timing
- Acceptance edge ends cycle T (IDLE, start=1, stall=1 in T).
- MUL*: MUL in T+1, DONE in T+2. Stall is high T..T+1 and low in T+2.
- DIV*/REM* normal: DIV_RUN T+1..T+32, DIV_FIX T+33, DONE T+34. Stall is high T..T+33.
- Special-case divide: DONE in T+1.
- In the DONE cycle the pipeline advances and EX/MEM captures result.
- The next M instruction reaches EX in T_done+1 with state IDLE. There are no back-to-back bubbles beyond the above.
- Throughput: one operation per (latency+1) cycles.

## Structure
- Package muldiv_pkg:
  - op encodings (OP_MUL … OP_REMU).
  - State enum.
  - DIV_ITERS = 32.
  - Divide-by-zero and overflow constants.
- Sub-module div_step: combinational one-iteration restoring step. Inputs: partial remainder, quotient, divisor. Outputs: next remainder and next quotient.
- The FSM, counter, operand registers and sign logic live in muldiv_sequencer.

## Test plan
- MUL 7×(−3) (0x00000007, 0xFFFFFFFD) → done at T+2 with result 0xFFFFFFEB; stall high exactly 2 cycles.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −20/3 → 0xFFFFFFFA at T+34; REM −20/3 → 0xFFFFFFFE; stall high 34 cycles.
- DIVU 100/0 → 0xFFFFFFFF at T+1; REM 0x80000000/0xFFFFFFFF → 0 at T+1; DIV same operands → 0x80000000.
- Start DIVU 1000/7, assert flush at T+10 → IDLE at T+11, no done, result keeps prior value. A following MUL 3×4 → 12 at T+13 when issued at T+11.
- Assert reset asynchronously at T+15 mid-divide → busy, done, stall, result all 0 immediately. start held through DONE does not cause a second acceptance.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the RV32M multiply/divide sequencer:
//   - funct3 operation encodings (OP_MUL .. OP_REMU)
//   - sequencer state enum
//   - divide iteration count and special-case result constants
//   - helpers that classify and resolve the divide fast-path cases
// -----------------------------------------------------------------------------
package muldiv_pkg;

  // funct3 encodings of the M extension
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL     = 3'd1,
    ST_DIV_RUN = 3'd2,
    ST_DIV_FIX = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int         DIV_ITERS     = 32;
  localparam logic [4:0] DIV_LAST_ITER = 5'(DIV_ITERS - 1);

  // Divide-by-zero: all-ones quotient, remainder is the dividend
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV0_DIVISOR  = 32'h0000_0000;

  // Signed overflow: most-negative / -1
  localparam logic [31:0] OVF_DIVIDEND  = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR   = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOTIENT  = 32'h8000_0000;
  localparam logic [31:0] OVF_REMAINDER = 32'h0000_0000;

  // True when the divide op resolves without iterating
  function automatic logic is_div_special(input logic [2:0]  op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed_op;
    signed_op = (op == OP_DIV) || (op == OP_REM);
    return (b == DIV0_DIVISOR) ||
           (signed_op && (a == OVF_DIVIDEND) && (b == OVF_DIVISOR));
  endfunction

  // Fast-path result; only meaningful when is_div_special() holds
  function automatic logic [31:0] div_special_result(input logic [2:0]  op,
                                                     input logic [31:0] a,
                                                     input logic [31:0] b);
    logic rem_op;
    logic [31:0] res;
    rem_op = (op == OP_REM) || (op == OP_REMU);
    if (b == DIV0_DIVISOR) begin
      res = rem_op ? a : DIV0_QUOTIENT;
    end else begin
      res = rem_op ? OVF_REMAINDER : OVF_QUOTIENT;
    end
    return res;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational iteration of an unsigned restoring divide.
// The {remainder, quotient} pair is shifted left by one; the divisor is
// subtracted from the widened partial remainder and the result kept only if
// it is non-negative, in which case a 1 enters the quotient LSB.
// Ports:
//   rem       in  WIDTH  current partial remainder
//   quo       in  WIDTH  current quotient / remaining dividend bits
//   divisor   in  WIDTH  divisor magnitude
//   rem_next  out WIDTH  partial remainder after this step
//   quo_next  out WIDTH  quotient after this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] trial_s;
  logic [WIDTH:0] diff_s;

  // Trial subtraction; the extra top bit keeps the shifted remainder exact
  always_comb begin
    trial_s = {rem, quo[WIDTH-1]};
    diff_s  = trial_s - {1'b0, divisor};
    if (diff_s[WIDTH]) begin
      rem_next = trial_s[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = diff_s[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// EX-stage controller for RV32M. Accepts one M-extension op from ID/EX,
// runs a single-cycle registered multiply or a 32-iteration restoring divide
// on operand magnitudes with a final sign fix, and presents the result for
// one DONE cycle while the pipeline stall drops.
// Ports:
//   clk        in   1     rising-edge clock
//   reset      in   1     asynchronous active-high reset
//   start      in   1     EX holds a valid M-extension instruction
//   op         in   3     funct3 operation select
//   operand_a  in   XLEN  rs1 value
//   operand_b  in   XLEN  rs2 value
//   flush      in   1     abort the in-flight operation
//   stall      out  1     freeze PC, IF/ID, ID/EX (combinational)
//   busy       out  1     sequencer not idle (registered)
//   done       out  1     result valid this cycle (registered)
//   result     out  XLEN  result, held until the next done
// -----------------------------------------------------------------------------
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e            state_r;
  state_e            state_s;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   a_r;
  logic [XLEN-1:0]   b_r;
  logic [XLEN-1:0]   divisor_r;
  logic [XLEN-1:0]   rem_r;
  logic [XLEN-1:0]   quo_r;
  logic [4:0]        cnt_r;
  logic [XLEN-1:0]   result_r;
  logic              busy_r;
  logic              done_r;

  logic              accept_s;
  logic              special_s;
  logic              in_signed_div_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic [2*XLEN-1:0] a_ext_s;
  logic [2*XLEN-1:0] b_ext_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   mul_result_s;
  logic [XLEN-1:0]   rem_step_s;
  logic [XLEN-1:0]   quo_step_s;
  logic              r_signed_div_s;
  logic              r_rem_op_s;
  logic [XLEN-1:0]   div_result_s;

  assign accept_s        = (state_r == ST_IDLE) && start && !flush;
  assign special_s       = is_div_special(op, operand_a, operand_b);
  assign in_signed_div_s = (op == OP_DIV) || (op == OP_REM);

  // Stall covers the acceptance cycle and every in-flight cycle, never DONE
  assign stall = !reset &&
                 (accept_s || ((state_r != ST_IDLE) && (state_r != ST_DONE)));
  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

  // Operand magnitudes for the divider, taken straight from the inputs
  always_comb begin
    if (in_signed_div_s && operand_a[XLEN-1]) begin
      a_mag_s = -operand_a;
    end else begin
      a_mag_s = operand_a;
    end
    if (in_signed_div_s && operand_b[XLEN-1]) begin
      b_mag_s = -operand_b;
    end else begin
      b_mag_s = operand_b;
    end
  end

  // Extend latched operands to 64 bits; the low 64 bits of the product are
  // exact for every signedness combination
  always_comb begin
    case (op_r)
      OP_MULH: begin
        a_ext_s = {{XLEN{a_r[XLEN-1]}}, a_r};
        b_ext_s = {{XLEN{b_r[XLEN-1]}}, b_r};
      end
      OP_MULHSU: begin
        a_ext_s = {{XLEN{a_r[XLEN-1]}}, a_r};
        b_ext_s = {{XLEN{1'b0}}, b_r};
      end
      default: begin
        a_ext_s = {{XLEN{1'b0}}, a_r};
        b_ext_s = {{XLEN{1'b0}}, b_r};
      end
    endcase
  end

  assign prod_s = a_ext_s * b_ext_s;

  // Pick the product half requested by the op
  always_comb begin
    case (op_r)
      OP_MULH, OP_MULHSU, OP_MULHU: mul_result_s = prod_s[2*XLEN-1:XLEN];
      default:                      mul_result_s = prod_s[XLEN-1:0];
    endcase
  end

  div_step #(
    .WIDTH(XLEN)
  ) u_div_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (divisor_r),
    .rem_next (rem_step_s),
    .quo_next (quo_step_s)
  );

  assign r_signed_div_s = (op_r == OP_DIV) || (op_r == OP_REM);
  assign r_rem_op_s     = (op_r == OP_REM) || (op_r == OP_REMU);

  // Sign fix: quotient negative iff signs differ, remainder follows dividend
  always_comb begin
    if (r_rem_op_s) begin
      if (r_signed_div_s && a_r[XLEN-1]) begin
        div_result_s = -rem_r;
      end else begin
        div_result_s = rem_r;
      end
    end else begin
      if (r_signed_div_s && (a_r[XLEN-1] ^ b_r[XLEN-1])) begin
        div_result_s = -quo_r;
      end else begin
        div_result_s = quo_r;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (!op[2]) begin
            state_s = ST_MUL;
          end else if (special_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_DIV_RUN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_DIV_RUN: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else if (cnt_r == DIV_LAST_ITER) begin
          state_s = ST_DIV_FIX;
        end else begin
          state_s = ST_DIV_RUN;
        end
      end
      ST_DIV_FIX: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register plus registered busy/done derived from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Operand latch, divide iteration registers and result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r      <= 3'b000;
      a_r       <= '0;
      b_r       <= '0;
      divisor_r <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      cnt_r     <= 5'd0;
      result_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r      <= op;
            a_r       <= operand_a;
            b_r       <= operand_b;
            divisor_r <= b_mag_s;
            rem_r     <= '0;
            quo_r     <= a_mag_s;
            cnt_r     <= 5'd0;
            if (op[2] && special_s) begin
              result_r <= div_special_result(op, operand_a, operand_b);
            end
          end
        end
        ST_MUL: begin
          if (!flush) begin
            result_r <= mul_result_s;
          end
        end
        ST_DIV_RUN: begin
          rem_r <= rem_step_s;
          quo_r <= quo_step_s;
          cnt_r <= cnt_r + 5'd1;
        end
        ST_DIV_FIX: begin
          if (!flush) begin
            result_r <= div_result_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench: a cycle-level behavioural model (latency countdown plus
// arithmetic reference) is compared against the DUT on every negative edge,
// directed ops pin latency/stall/result literally, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        start     = 1'b0;
  logic        flush     = 1'b0;
  logic [2:0]  op        = 3'b000;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Arithmetic reference using 64-bit integer math
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 64'd0;
    case (o)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Cycles from acceptance to the DONE cycle
  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (!o[2]) return 2;
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Behavioural model: cycles left until DONE, expected done and result
  int          m_left    = 0;
  bit          m_done    = 1'b0;
  logic [31:0] m_result  = 32'd0;
  logic [31:0] m_pending = 32'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left   <= 0;
      m_done   <= 1'b0;
      m_result <= 32'd0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      if (flush) begin
        m_left <= 0;
      end else if (m_left == 1) begin
        m_left   <= 0;
        m_done   <= 1'b1;
        m_result <= m_pending;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (start && !flush) begin
      if (ref_lat(op, operand_a, operand_b) == 1) begin
        m_done   <= 1'b1;
        m_result <= ref_result(op, operand_a, operand_b);
      end else begin
        m_left    <= ref_lat(op, operand_a, operand_b) - 1;
        m_pending <= ref_result(op, operand_a, operand_b);
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall),
          32'(!reset && ((m_left > 0) || (!m_done && start && !flush))));
      chk("busy", 32'(busy), 32'((m_left > 0) || m_done));
      chk("done", 32'(done), 32'(m_done));
      chk("result", result, m_result);
    end
  end

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op (caller is just after a rising edge) holding start to DONE
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    int cyc;
    int stalls;
    int done_at;
    bit seen;
    cyc = 0; stalls = 0; done_at = -1; seen = 1'b0;
    start = 1'b1; flush = 1'b0; op = o; operand_a = a; operand_b = b;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) begin
        seen = 1'b1;
        done_at = cyc;
      end
      if (!seen && cyc >= 1) begin
        op = ~o; operand_a = ~a; operand_b = b ^ 32'h5A5A_5A5A;
      end
      cyc++;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_latency"}, done_at, lat);
    chk({name, "_result"}, result, exp);
    chk({name, "_stall_cycles"}, stalls, lat);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({name, "_no_restart"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit early_done;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_result", result, 32'd0);
    chk_en = 1'b1;

    // Pin the reference model with hand-computed values
    chk("ref_mul", ref_result(3'b000, 32'h7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("ref_mulhu", ref_result(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    chk("ref_mulhsu", ref_result(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    chk("ref_div", ref_result(3'b100, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFA);
    chk("ref_rem", ref_result(3'b110, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFE);
    chk("ref_rem_ovf", ref_result(3'b110, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

    // Directed ops with literal expectations
    @(posedge clk); #1; run_op(3'b000, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, "mul");
    @(posedge clk); #1; run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, "mulhu");
    @(posedge clk); #1; run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, "mulhsu");
    @(posedge clk); #1; run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 2, "mulh");
    @(posedge clk); #1; run_op(3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34, "div");
    @(posedge clk); #1; run_op(3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34, "rem");
    @(posedge clk); #1; run_op(3'b101, 32'd1000, 32'd7, 32'd142, 34, "divu");
    @(posedge clk); #1; run_op(3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
    @(posedge clk); #1; run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
    @(posedge clk); #1; run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    @(posedge clk); #1; run_op(3'b111, 32'd100, 32'd0, 32'd100, 1, "remu_by0");

    // Flush mid-divide at T+10, then MUL issued at T+11
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b0; op = 3'b101; operand_a = 32'd1000; operand_b = 32'd7;
    early_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) early_done = 1'b1;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    if (done) early_done = 1'b1;
    @(posedge clk); #1;
    chk("flush_no_done", 32'(early_done), 32'd0);
    chk("flush_idle", 32'(busy), 32'd0);
    chk("flush_result_kept", result, 32'd100);
    run_op(3'b000, 32'd3, 32'd4, 32'd12, 2, "mul_after_flush");

    // Asynchronous reset mid-divide at T+15
    @(posedge clk); #1;
    start = 1'b1; op = 3'b100; operand_a = 32'hFFFF_FFEC; operand_b = 32'd3;
    repeat (15) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_done", 32'(done), 32'd0);
    chk("areset_stall", 32'(stall), 32'd0);
    chk("areset_result", result, 32'd0);
    start = 1'b0;
    @(posedge clk); #3 reset = 1'b0;

    // Randomized traffic, including operand churn and occasional flushes
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start     = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      op        = 3'($urandom_range(0, 7));
      operand_a = rand_operand();
      operand_b = rand_operand();
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
